// File: rtl/sodor_2stage_state_loader_if.sv
// Snapshot stream, scratchpad write port and committed state image of the
// 2-stage Sodor state loader. The host drives "master", the loader is "slave".
interface sodor_2stage_state_loader_if;
    logic [31:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic          err_clear;
    logic          mem_wr_en;
    logic [2:0]    mem_wr_bank;
    logic [7:0]    mem_wr_addr;
    logic [31:0]   mem_wr_data;
    logic          ld_valid;
    logic [1023:0] ld_regfile;
    logic [191:0]  ld_pipe;
    logic [18:0]   ld_flags;
    logic [255:0]  ld_csr;
    logic [63:0]   ld_cnt0;
    logic [63:0]   ld_cnt1;
    logic          busy;
    logic          error;

    modport master (
        output in_data, in_valid, err_clear,
        input  in_ready, mem_wr_en, mem_wr_bank, mem_wr_addr, mem_wr_data,
        input  ld_valid, ld_regfile, ld_pipe, ld_flags, ld_csr, ld_cnt0, ld_cnt1,
        input  busy, error
    );

    modport slave (
        input  in_data, in_valid, err_clear,
        output in_ready, mem_wr_en, mem_wr_bank, mem_wr_addr, mem_wr_data,
        output ld_valid, ld_regfile, ld_pipe, ld_flags, ld_csr, ld_cnt0, ld_cnt1,
        output busy, error
    );
endinterface

// File: rtl/sodor_2stage_state_loader.sv
// Deserializes a checksummed snapshot frame into staging registers, streams the
// optional memory image to the scratchpad, and commits the state image on a good trailer.
module sodor_2stage_state_loader (
    input  logic                        clock,
    input  logic                        reset_n,
    sodor_2stage_state_loader_if.slave  bus
);
    localparam logic [27:0] MAGIC       = 28'h50D225A;
    localparam int          NUM_STAGED  = 51;
    localparam logic [10:0] LAST_STAGED = 11'd50;
    localparam logic [10:0] LAST_MEM    = 11'd2047;
    localparam int          PIPE_BASE   = 32;
    localparam int          FLAGS_IDX   = 38;
    localparam int          CSR_BASE    = 39;
    localparam int          CNT_BASE    = 47;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_REGS,
        S_MEM,
        S_CHECK,
        S_COMMIT,
        S_ERROR
    } state_e;

    state_e        state_q, state_d;
    logic [10:0]   cnt_q, cnt_d;
    logic [31:0]   csum_q, csum_d;
    logic          mem_en_q, mem_en_d;
    logic [31:0]   stage_q [NUM_STAGED];
    logic [31:0]   stage_d [NUM_STAGED];

    logic          mem_wr_en_q, mem_wr_en_d;
    logic [2:0]    mem_wr_bank_q, mem_wr_bank_d;
    logic [7:0]    mem_wr_addr_q, mem_wr_addr_d;
    logic [31:0]   mem_wr_data_q, mem_wr_data_d;

    logic [1023:0] ld_regfile_q, ld_regfile_d;
    logic [191:0]  ld_pipe_q, ld_pipe_d;
    logic [18:0]   ld_flags_q, ld_flags_d;
    logic [255:0]  ld_csr_q, ld_csr_d;
    logic [63:0]   ld_cnt0_q, ld_cnt0_d;
    logic [63:0]   ld_cnt1_q, ld_cnt1_d;

    logic          in_ready;
    logic          accept;
    logic          hdr_ok;

    logic [1023:0] img_regfile;
    logic [191:0]  img_pipe;
    logic [18:0]   img_flags;
    logic [255:0]  img_csr;
    logic [63:0]   img_cnt0;
    logic [63:0]   img_cnt1;
    logic          unused_stage_bits;

    assign in_ready = (state_q == S_IDLE) || (state_q == S_REGS) ||
                      (state_q == S_MEM)  || (state_q == S_CHECK);
    assign accept   = bus.in_valid && in_ready;
    assign hdr_ok   = (bus.in_data[31:4] == MAGIC) && (bus.in_data[3:1] == 3'b000);

    // Staged words viewed as the state image the core expects.
    always_comb begin
        img_regfile = '0;
        img_pipe    = '0;
        img_csr     = '0;
        for (int i = 0; i < 32; i++) img_regfile[32*i +: 32] = stage_q[i];
        for (int i = 0; i < 6; i++)  img_pipe[32*i +: 32]    = stage_q[PIPE_BASE + i];
        for (int i = 0; i < 8; i++)  img_csr[32*i +: 32]     = stage_q[CSR_BASE + i];
        img_flags = stage_q[FLAGS_IDX][18:0];
        img_cnt0  = {6'b0, stage_q[CNT_BASE + 1][25:0], stage_q[CNT_BASE]};
        img_cnt1  = {6'b0, stage_q[CNT_BASE + 3][25:0], stage_q[CNT_BASE + 2]};
    end

    assign unused_stage_bits = ^{stage_q[FLAGS_IDX][31:19],
                                 stage_q[CNT_BASE + 1][31:26],
                                 stage_q[CNT_BASE + 3][31:26]};

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        csum_d        = csum_q;
        mem_en_d      = mem_en_q;
        stage_d       = stage_q;
        mem_wr_en_d   = 1'b0;
        mem_wr_bank_d = mem_wr_bank_q;
        mem_wr_addr_d = mem_wr_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        ld_regfile_d  = ld_regfile_q;
        ld_pipe_d     = ld_pipe_q;
        ld_flags_d    = ld_flags_q;
        ld_csr_d      = ld_csr_q;
        ld_cnt0_d     = ld_cnt0_q;
        ld_cnt1_d     = ld_cnt1_q;

        unique case (state_q)
            S_INIT: state_d = S_IDLE;
            S_IDLE: begin
                if (accept) begin
                    if (hdr_ok) begin
                        csum_d   = bus.in_data;
                        mem_en_d = bus.in_data[0];
                        cnt_d    = '0;
                        state_d  = S_REGS;
                    end else begin
                        state_d  = S_ERROR;
                    end
                end
            end
            S_REGS: begin
                if (accept) begin
                    stage_d[cnt_q[5:0]] = bus.in_data;
                    csum_d = csum_q ^ bus.in_data;
                    if (cnt_q == LAST_STAGED) begin
                        cnt_d   = '0;
                        state_d = mem_en_q ? S_MEM : S_CHECK;
                    end else begin
                        cnt_d   = cnt_q + 11'd1;
                    end
                end
            end
            S_MEM: begin
                // The 11-bit word index splits directly into bank and address.
                if (accept) begin
                    mem_wr_en_d   = 1'b1;
                    mem_wr_bank_d = cnt_q[10:8];
                    mem_wr_addr_d = cnt_q[7:0];
                    mem_wr_data_d = bus.in_data;
                    csum_d        = csum_q ^ bus.in_data;
                    cnt_d         = cnt_q + 11'd1;
                    if (cnt_q == LAST_MEM) state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (accept) begin
                    if (bus.in_data == csum_q) begin
                        ld_regfile_d = img_regfile;
                        ld_pipe_d    = img_pipe;
                        ld_flags_d   = img_flags;
                        ld_csr_d     = img_csr;
                        ld_cnt0_d    = img_cnt0;
                        ld_cnt1_d    = img_cnt1;
                        state_d      = S_COMMIT;
                    end else begin
                        state_d      = S_ERROR;
                    end
                end
            end
            S_COMMIT: state_d = S_IDLE;
            S_ERROR:  if (bus.err_clear) state_d = S_IDLE;
            default:  state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_INIT;
            cnt_q         <= '0;
            csum_q        <= '0;
            mem_en_q      <= 1'b0;
            for (int i = 0; i < NUM_STAGED; i++) stage_q[i] <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_bank_q <= '0;
            mem_wr_addr_q <= '0;
            mem_wr_data_q <= '0;
            ld_regfile_q  <= '0;
            ld_pipe_q     <= '0;
            ld_flags_q    <= '0;
            ld_csr_q      <= '0;
            ld_cnt0_q     <= '0;
            ld_cnt1_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            csum_q        <= csum_d;
            mem_en_q      <= mem_en_d;
            stage_q       <= stage_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_wr_bank_q <= mem_wr_bank_d;
            mem_wr_addr_q <= mem_wr_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            ld_regfile_q  <= ld_regfile_d;
            ld_pipe_q     <= ld_pipe_d;
            ld_flags_q    <= ld_flags_d;
            ld_csr_q      <= ld_csr_d;
            ld_cnt0_q     <= ld_cnt0_d;
            ld_cnt1_q     <= ld_cnt1_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.error       = (state_q == S_ERROR);
    assign bus.ld_valid    = (state_q == S_COMMIT);
    assign bus.mem_wr_en   = mem_wr_en_q;
    assign bus.mem_wr_bank = mem_wr_bank_q;
    assign bus.mem_wr_addr = mem_wr_addr_q;
    assign bus.mem_wr_data = mem_wr_data_q;
    assign bus.ld_regfile  = ld_regfile_q;
    assign bus.ld_pipe     = ld_pipe_q;
    assign bus.ld_flags    = ld_flags_q;
    assign bus.ld_csr      = ld_csr_q;
    assign bus.ld_cnt0     = ld_cnt0_q;
    assign bus.ld_cnt1     = ld_cnt1_q;
endmodule

// File: tb/tb_sodor_2stage_state_loader.sv
// Frame-level bench: builds snapshot frames from payload arrays, predicts the
// committed image and memory writes from the frame layout, checks every cycle.
module tb_sodor_2stage_state_loader;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    sodor_2stage_state_loader_if bus ();
    sodor_2stage_state_loader dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] pl [51];
    logic [31:0] frame [$];

    // Pending expectations, written by the driver.
    logic [1023:0] p_reg;
    logic [191:0]  p_pipe;
    logic [18:0]   p_flags;
    logic [255:0]  p_csr;
    logic [63:0]   p_c0, p_c1;
    logic [2:0]    ew_bank;
    logic [7:0]    ew_addr;
    logic [31:0]   ew_data;
    int            wr_issued = 0;
    int            ld_issued = 0;

    // Committed image and bookkeeping, owned by the compare process.
    logic [1023:0] e_reg   = '0;
    logic [191:0]  e_pipe  = '0;
    logic [18:0]   e_flags = '0;
    logic [255:0]  e_csr   = '0;
    logic [63:0]   e_c0    = '0, e_c1 = '0;
    int            wr_acked = 0;
    int            ld_acked = 0;
    int            wr_count = 0;
    logic [31:0]   d_b1_a44 = '0;
    logic [31:0]   d_b7_a255 = '0;
    bit            cmp_exp_wr, cmp_exp_ld;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_w(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            for (int i = 0; i < 32; i++)
                if (act[32*i +: 32] !== exp[32*i +: 32]) begin
                    $display("FAIL %s word %0d: got 0x%08h, expected 0x%08h",
                             name, i, act[32*i +: 32], exp[32*i +: 32]);
                    break;
                end
        end
    endtask

    always @(negedge clock) begin
        if (!reset_n) begin
            e_reg = '0; e_pipe = '0; e_flags = '0; e_csr = '0; e_c0 = '0; e_c1 = '0;
            wr_acked = wr_issued;
            ld_acked = ld_issued;
        end else begin
            cmp_exp_ld = (ld_acked != ld_issued);
            cmp_exp_wr = (wr_acked != wr_issued);
            check("ld_valid", 64'(bus.ld_valid), 64'(cmp_exp_ld));
            if (cmp_exp_ld) begin
                e_reg = p_reg; e_pipe = p_pipe; e_flags = p_flags;
                e_csr = p_csr; e_c0 = p_c0; e_c1 = p_c1;
                ld_acked = ld_issued;
            end
            check_w("ld_regfile", bus.ld_regfile, e_reg);
            check_w("ld_pipe", 1024'(bus.ld_pipe), 1024'(e_pipe));
            check_w("ld_csr", 1024'(bus.ld_csr), 1024'(e_csr));
            check("ld_flags", 64'(bus.ld_flags), 64'(e_flags));
            check("ld_cnt0", bus.ld_cnt0, e_c0);
            check("ld_cnt1", bus.ld_cnt1, e_c1);
            check("mem_wr_en", 64'(bus.mem_wr_en), 64'(cmp_exp_wr));
            if (cmp_exp_wr && bus.mem_wr_en)
                check("mem_wr", 64'({bus.mem_wr_bank, bus.mem_wr_addr, bus.mem_wr_data}),
                      64'({ew_bank, ew_addr, ew_data}));
            wr_acked = wr_issued;
            if (bus.mem_wr_en) begin
                wr_count++;
                if (bus.mem_wr_bank == 3'd1 && bus.mem_wr_addr == 8'd44)  d_b1_a44  = bus.mem_wr_data;
                if (bus.mem_wr_bank == 3'd7 && bus.mem_wr_addr == 8'd255) d_b7_a255 = bus.mem_wr_data;
            end
        end
    end

    task automatic build_frame(input bit mem_en, input logic [31:0] trl_xor);
        logic [31:0] cs;
        frame.delete();
        frame.push_back({28'h50D225A, 3'b000, mem_en});
        for (int i = 0; i < 51; i++) frame.push_back(pl[i]);
        if (mem_en) for (int k = 0; k < 2048; k++) frame.push_back(32'(k));
        cs = '0;
        foreach (frame[i]) cs ^= frame[i];
        frame.push_back(cs ^ trl_xor);
    endtask

    task automatic make_expect();
        for (int i = 0; i < 32; i++) p_reg[32*i +: 32] = pl[i];
        for (int i = 0; i < 6; i++)  p_pipe[32*i +: 32] = pl[32 + i];
        for (int i = 0; i < 8; i++)  p_csr[32*i +: 32] = pl[39 + i];
        p_flags = pl[38][18:0];
        p_c0 = {6'b0, pl[48][25:0], pl[47]};
        p_c1 = {6'b0, pl[50][25:0], pl[49]};
    endtask

    // Caller is at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] w, input int gap_pct, output bit ok, output int tries);
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            @(posedge clock); #1;
        end
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        tries = 0;
        for (int t = 0; t < 64; t++) begin
            @(negedge clock);
            if (bus.in_ready) begin ok = 1'b1; break; end
            tries++;
        end
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        if (!ok) check("handshake_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_frame(input bit mem_en, input int gap, input logic [31:0] trl_xor,
                             input int abort_at, input bit b2b);
        bit ok;
        int tries;
        logic [10:0] k;
        build_frame(mem_en, trl_xor);
        make_expect();
        for (int i = 0; i < frame.size(); i++) begin
            if (i == abort_at) return;
            send(frame[i], (i == 0 && b2b) ? 0 : gap, ok, tries);
            if (!ok) return;
            if (i == 0 && b2b) check("b2b_header_wait", 64'(tries), 64'd0);
            if (mem_en && i >= 52 && i < 2100) begin
                k = 11'(i - 52);
                ew_bank = k[10:8];
                ew_addr = k[7:0];
                ew_data = 32'(k);
                wr_issued++;
            end
        end
        if (trl_xor == 32'd0) begin
            ld_issued++;
            @(negedge clock);
            check("commit_in_ready", 64'(bus.in_ready), 64'd0);
            check("commit_busy", 64'(bus.busy), 64'd1);
        end else begin
            @(negedge clock);
            check("csum_error", 64'(bus.error), 64'd1);
            check("csum_in_ready", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.err_clear = 1'b0;
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;
        @(negedge clock);
        check("init_in_ready", 64'(bus.in_ready), 64'd0);
        check("init_busy", 64'(bus.busy), 64'd1);
        check("init_error", 64'(bus.error), 64'd0);
        check("init_ld_regfile", 64'(bus.ld_regfile[63:0]), 64'd0);
        @(posedge clock); #1;
        @(negedge clock);
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);
        check("idle_busy", 64'(bus.busy), 64'd0);
        @(posedge clock); #1;
    endtask

    task automatic clear_error();
        bus.in_data  = $urandom;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("err_hold_in_ready", 64'(bus.in_ready), 64'd0);
            check("err_hold_error", 64'(bus.error), 64'd1);
        end
        @(posedge clock); #1;
        bus.in_valid  = 1'b0;
        bus.err_clear = 1'b1;
        @(posedge clock); #1;
        bus.err_clear = 1'b0;
        @(negedge clock);
        check("err_clear_error", 64'(bus.error), 64'd0);
        check("err_clear_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clock); #1;
    endtask

    task automatic rand_payload();
        for (int i = 0; i < 51; i++) pl[i] = $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int tries;
        int wc0;
        logic [1023:0] g_reg;
        logic [255:0]  g_csr;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.err_clear = 1'b0;
        do_reset();

        // Register-only frame with hand-computed values.
        for (int i = 0; i < 51; i++) pl[i] = '0;
        pl[5]  = 32'hDEADBEEF;
        pl[32] = 32'h80000000;
        pl[38] = 32'h0007FFFF;
        pl[46] = 32'h00000100;
        build_frame(1'b0, 32'd0);
        check("frame_trailer", 64'(frame[frame.size()-1]), 64'h0E7865B0);
        wc0 = wr_count;
        run_frame(1'b0, 0, 32'd0, -1, 1'b0);
        check("lit_x5", 64'(bus.ld_regfile[191:160]), 64'hDEADBEEF);
        check("lit_if_reg_pc", 64'(bus.ld_pipe[31:0]), 64'h80000000);
        check("lit_flags", 64'(bus.ld_flags), 64'h7FFFF);
        check("lit_mtvec", 64'(bus.ld_csr[255:224]), 64'h100);
        check("lit_no_writes", 64'(wr_count - wc0), 64'd0);

        // Memory frame, back-to-back after the previous commit.
        rand_payload();
        wc0 = wr_count;
        run_frame(1'b1, 0, 32'd0, -1, 1'b1);
        check("mem_write_count", 64'(wr_count - wc0), 64'd2048);
        check("mem_word300", 64'(d_b1_a44), 64'd300);
        check("mem_word2047", 64'(d_b7_a255), 64'd2047);

        // Checksum mismatch, recovery, then a good frame.
        rand_payload();
        run_frame(1'b0, 0, 32'd1, -1, 1'b0);
        clear_error();
        rand_payload();
        run_frame(1'b0, 20, 32'd0, -1, 1'b0);

        // Bad header goes straight to ERROR.
        send(32'h50D225A2, 0, ok, tries);
        @(negedge clock);
        check("bad_hdr_error", 64'(bus.error), 64'd1);
        check("bad_hdr_busy", 64'(bus.busy), 64'd1);
        @(posedge clock); #1;
        clear_error();

        // Same payload gap-free and with ~50% valid gaps must commit the same image.
        rand_payload();
        run_frame(1'b1, 0, 32'd0, -1, 1'b0);
        g_reg = bus.ld_regfile;
        g_csr = bus.ld_csr;
        run_frame(1'b1, 50, 32'd0, -1, 1'b1);
        check_w("gap_regfile", bus.ld_regfile, g_reg);
        check_w("gap_csr", 1024'(bus.ld_csr), 1024'(g_csr));

        // Reset at payload word 20 aborts the frame and clears the image.
        rand_payload();
        run_frame(1'b0, 50, 32'd0, 21, 1'b0);
        do_reset();
        check_w("reset_ld_regfile", bus.ld_regfile, '0);
        check("reset_ld_valid", 64'(bus.ld_valid), 64'd0);

        rand_payload();
        run_frame(1'b0, 30, 32'd0, -1, 1'b0);
        repeat (3) @(posedge clock);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
